pipe_stage_reg: RTL

- Generic, parametrised pipeline-stage register. It is the successor to the fixed per-stage latch and is used between any two core stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Payload is split into two fields. CTRL holds the side-effect enables (reg_write, mem_write, mem_read, ...). DATA holds the values (pc, alu_out, rs2 data, rd addr, funct3, ...).
- Adds a valid/ready handshake for stall support, a synchronous flush for kill, an optional skid buffer to register the ready path, and masking of control when the stage holds a bubble.

---
 rtl/pipe_stage_reg.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline-stage register placed between two core stages. Each beat
// carries a control field (side-effect enables such as reg_write/mem_write)
// and a data field (pc, alu result, operands, rd, funct3, ...). The stage uses
// a valid/ready handshake for stalls and a synchronous flush for kills. The
// control field is masked to zero whenever the stage presents a bubble.
//
// Parameters:
//   CTRL_W  width of the control field (zeroed on bubbles)
//   DATA_W  width of the data field
//   SKID    1: two-entry skid buffer, in_ready comes straight from a flop
//           0: single entry, in_ready is combinational from out_ready
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat this cycle
//   in_ctrl    upstream control field
//   in_data    upstream data field
//   flush      synchronous kill of all held beats
//   out_valid  downstream beat present
//   out_ready  downstream accepts
//   out_ctrl   control field, all-zero while out_valid=0
//   out_data   data field, stale-but-stable while out_valid=0
//   occupancy  number of held beats (0..2, at most 1 when SKID=0)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 5,
    parameter int unsigned DATA_W = 104,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Main entry: always the one presented downstream.
    logic              m_valid_q, m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;

    // Skid-entry valid as seen from the shared output logic (0 when SKID=0).
    logic              skid_valid;
    logic              accept;

    assign accept = in_valid & in_ready;

    // NOTE: sequential state uses non-blocking assignments only; all
    // next-state decisions are made in always_comb on the _d signals.
    // NOTE: ctrl/data payload registers are reset as well, so out_data reads
    // a defined zero straight out of reset rather than X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_ctrl_q  <= '0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_ctrl_q  <= m_ctrl_d;
            m_data_q  <= m_data_d;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic              s_valid_q, s_valid_d;
            logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
            logic [DATA_W-1:0] s_data_q,  s_data_d;
            logic              in_ready_q;

            // NOTE: every signal written here gets a default first, so no
            // path through the branches can infer a latch.
            always_comb begin
                m_valid_d = m_valid_q;
                m_ctrl_d  = m_ctrl_q;
                m_data_d  = m_data_q;
                s_valid_d = s_valid_q;
                s_ctrl_d  = s_ctrl_q;
                s_data_d  = s_data_q;

                if (flush) begin
                    // Kill only the valid bits; payload keeps its stale value.
                    m_valid_d = 1'b0;
                    s_valid_d = 1'b0;
                end else if (!m_valid_q || out_ready) begin
                    // Main is free this edge. The skid beat is older than
                    // anything on the input, so it moves first. An accept
                    // cannot coincide with a full skid (in_ready=~s_valid).
                    if (s_valid_q) begin
                        m_valid_d = 1'b1;
                        m_ctrl_d  = s_ctrl_q;
                        m_data_d  = s_data_q;
                        s_valid_d = 1'b0;
                    end else if (accept) begin
                        m_valid_d = 1'b1;
                        m_ctrl_d  = in_ctrl;
                        m_data_d  = in_data;
                    end else begin
                        m_valid_d = 1'b0;
                    end
                end else if (accept) begin
                    // Main is stalled: park the new beat behind it.
                    s_valid_d = 1'b1;
                    s_ctrl_d  = in_ctrl;
                    s_data_d  = in_data;
                end
            end

            // in_ready is its own flop, computed from the skid next state,
            // so the ready path to upstream is fully registered.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_valid_q  <= 1'b0;
                    s_ctrl_q   <= '0;
                    s_data_q   <= '0;
                    in_ready_q <= 1'b1;
                end else begin
                    s_valid_q  <= s_valid_d;
                    s_ctrl_q   <= s_ctrl_d;
                    s_data_q   <= s_data_d;
                    in_ready_q <= ~s_valid_d;
                end
            end

            assign in_ready   = in_ready_q;
            assign skid_valid = s_valid_q;
        end else begin : g_noskid
            always_comb begin
                m_valid_d = m_valid_q;
                m_ctrl_d  = m_ctrl_q;
                m_data_d  = m_data_q;

                if (flush) begin
                    m_valid_d = 1'b0;
                end else if (accept) begin
                    m_valid_d = 1'b1;
                    m_ctrl_d  = in_ctrl;
                    m_data_d  = in_data;
                end else if (m_valid_q && out_ready) begin
                    m_valid_d = 1'b0;
                end
            end

            // Free whenever the held beat leaves this cycle or nothing is held.
            assign in_ready   = out_ready | ~m_valid_q;
            assign skid_valid = 1'b0;
        end
    endgenerate

    assign out_valid = m_valid_q;
    // Masking keeps stale write enables from reaching the next stage.
    assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
    assign out_data  = m_data_q;
    assign occupancy = {1'b0, m_valid_q} + {1'b0, skid_valid};

endmodule
